// File: rtl/axis_pkt_sink.sv
// AXI4-Stream byte sink: FWFT FIFO toward a local consumer, plus per-packet
// length/checksum/count characterisation on ingress.
module axis_pkt_sink #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [DATA_W-1:0]        s_axis_tdata,
    input  logic                     s_axis_tlast,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     in_pkt,
    output logic                     pkt_done,
    output logic [7:0]               pkt_len,
    output logic [7:0]               pkt_sum,
    output logic [15:0]              pkt_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic [0:0] {StIdle, StRx} state_e;

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;

    state_e            state_q;
    logic [7:0]        len_acc_q, sum_acc_q;
    logic              pkt_done_q;
    logic [7:0]        pkt_len_q, pkt_sum_q;
    logic [15:0]       pkt_cnt_q;

    logic              accept, pop;
    logic [7:0]        len_inc, sum_inc;
    logic [DATA_W:0]   head;

    // Ready comes from registered level only; a same-cycle pop never frees a full slot.
    assign s_axis_tready = rst && (level_q != LvlW'(DEPTH));
    assign rd_valid      = (level_q != '0);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign pop           = rd_en && rd_valid;

    assign head    = mem_q[rd_ptr_q];
    assign rd_data = rd_valid ? head[DATA_W-1:0] : '0;
    assign rd_last = rd_valid ? head[DATA_W] : 1'b0;
    assign level   = level_q;

    assign len_inc = (len_acc_q == 8'hFF) ? 8'hFF : len_acc_q + 8'd1;
    assign sum_inc = sum_acc_q + s_axis_tdata[7:0];

    assign in_pkt   = (state_q == StRx);
    assign pkt_done = pkt_done_q;
    assign pkt_len  = pkt_len_q;
    assign pkt_sum  = pkt_sum_q;
    assign pkt_cnt  = pkt_cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (accept) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (accept && !pop)      level_d = level_q + LvlW'(1);
        else if (pop && !accept) level_d = level_q - LvlW'(1);
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            len_acc_q  <= '0;
            sum_acc_q  <= '0;
            pkt_done_q <= 1'b0;
            pkt_len_q  <= '0;
            pkt_sum_q  <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            pkt_done_q <= 1'b0;
            if (accept) begin
                if (s_axis_tlast) begin
                    state_q    <= StIdle;
                    pkt_len_q  <= len_inc;
                    pkt_sum_q  <= sum_inc;
                    pkt_cnt_q  <= pkt_cnt_q + 16'd1;
                    pkt_done_q <= 1'b1;
                    len_acc_q  <= '0;
                    sum_acc_q  <= '0;
                end else begin
                    state_q   <= StRx;
                    len_acc_q <= len_inc;
                    sum_acc_q <= sum_inc;
                end
            end
        end
    end

endmodule
